// File: rtl/fp_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp_ctrl_pkg
// Purpose  : Shared state encoding, ALU opcodes and control bundle for the
//            floating-point sequencer.
// Revision : 1.0
// ============================================================================
package fp_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_EXP   = 3'd1,
      ST_ALIGN = 3'd2,
      ST_ADD   = 3'd3,
      ST_NORM  = 3'd4,
      ST_ROUND = 3'd5,
      ST_DONE  = 3'd6
   } state_e;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_MUL = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0011;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_MUL = 1'b1;

   // Alignment saturation for a single-precision mantissa (hidden bit included).
   localparam int MAX_ALIGN   = 24;
   localparam int MAX_EXP_ADJ = 15;

   typedef struct packed {
      logic               mux01;
      logic               mux02;
      logic               mux03;
      logic               mux04;
      logic               mux05;
      logic               mux06;
      logic [7:0]         shift_right;
      logic [3:0]         inc_dec_amt;
      logic               inc_dec_en;
      logic signed [22:0] shift_lr;
      logic               mux_a;
      logic               mux_b;
      logic               mux_sel;
      logic               sum_or_mul;
      logic               load_a;
      logic               load_b;
      logic [3:0]         big_op;
      logic               mux_a_small;
      logic               mux_b_small;
      logic               load_small;
      logic [3:0]         small_op;
      logic               busy;
      logic               done;
   } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/fp_ctrl_sat_abs.sv
`default_nettype none
// ============================================================================
// Module   : fp_ctrl_sat_abs
// Purpose  : Absolute value of a signed operand, clamped to SAT.
// Revision : 1.0
// ============================================================================
module fp_ctrl_sat_abs #(
   parameter int          IN_W  = 8,
   parameter int          OUT_W = 8,
   parameter int unsigned SAT   = 24
) (
   input  logic signed [IN_W-1:0] i_value,
   output logic        [OUT_W-1:0] o_abs
);

   // One extra bit so the most negative input has a representable magnitude.
   logic signed [IN_W:0] w_ext;
   logic        [IN_W:0] w_mag;

   assign w_ext = {i_value[IN_W-1], i_value};
   assign w_mag = i_value[IN_W-1] ? -w_ext : w_ext;

   always_comb begin
      o_abs = OUT_W'(w_mag);
      if (32'(w_mag) > SAT) begin
         o_abs = OUT_W'(SAT);
      end
   end

endmodule
`default_nettype wire

// File: rtl/floating_point_control.sv
`default_nettype none
// ============================================================================
// Module   : floating_point_control
// Purpose  : Moore sequencer driving the small/big ALU and shifters of an
//            FP add/multiply datapath; all controls come straight from flops.
// Revision : 1.0
// ============================================================================
module floating_point_control
   import fp_ctrl_pkg::*;
#(
   parameter int EXP_W  = 8,
   parameter int MANT_W = MAX_ALIGN - 1
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    start,
   input  logic                    operation,
   input  logic signed [EXP_W-1:0] expDiff,
   input  logic signed [5:0]       normalizeAmount,
   input  logic                    roundCarry,
   output logic                    controlToMux01,
   output logic                    controlToMux02,
   output logic                    controlToMux03,
   output logic                    controlToMux04,
   output logic                    controlToMux05,
   output logic                    controlToMux06,
   output logic [7:0]              controlShiftRight,
   output logic [3:0]              controlToIncreaseOrDecrease,
   output logic                    IncreaseOrDecreaseEnable,
   output logic signed [22:0]      controlShiftLeftOrRight,
   output logic                    muxAControl,
   output logic                    muxBControl,
   output logic                    muxControl,
   output logic                    sumOrMultiplication,
   output logic                    loadRegA,
   output logic                    loadRegB,
   output logic [3:0]              bigALUOperation,
   output logic                    muxAControlSmall,
   output logic                    muxBControlSmall,
   output logic                    loadRegSmall,
   output logic [3:0]              smallALUOperation,
   output logic                    busy,
   output logic                    done
);

   state_e                  state_q, state_d;
   logic                    op_q, op_d;
   logic signed [EXP_W-1:0] exp_diff_q, exp_diff_d;
   logic                    renorm_q, renorm_d;
   ctrl_t                   ctrl_q, ctrl_d;

   logic [7:0]              w_align_amt;
   logic [3:0]              w_norm_amt;

   fp_ctrl_sat_abs #(
      .IN_W  (EXP_W),
      .OUT_W (8),
      .SAT   (MANT_W + 1)
   ) u_align_abs (
      .i_value (exp_diff_d),
      .o_abs   (w_align_amt)
   );

   fp_ctrl_sat_abs #(
      .IN_W  (6),
      .OUT_W (4),
      .SAT   (MAX_EXP_ADJ)
   ) u_norm_abs (
      .i_value (normalizeAmount),
      .o_abs   (w_norm_amt)
   );

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      exp_diff_d = exp_diff_q;
      renorm_d   = renorm_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d  = ST_EXP;
               op_d     = operation;
               renorm_d = 1'b0;
            end
         end
         ST_EXP: begin
            exp_diff_d = expDiff;
            state_d    = (op_q == OP_MUL) ? ST_ADD : ST_ALIGN;
         end
         ST_ALIGN: state_d = ST_ADD;
         ST_ADD:   state_d = ST_NORM;
         ST_NORM:  state_d = ST_ROUND;
         ST_ROUND: begin
            // A rounding overflow earns exactly one extra normalize pass.
            if (roundCarry && !renorm_q) begin
               state_d  = ST_NORM;
               renorm_d = 1'b1;
            end else begin
               state_d = ST_DONE;
            end
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Controls are decoded for the state being entered so they register with it.
   always_comb begin
      ctrl_d      = '0;
      ctrl_d.busy = (state_d != ST_IDLE);
      case (state_d)
         ST_EXP: begin
            ctrl_d.small_op   = (op_d == OP_MUL) ? ALU_ADD : ALU_SUB;
            ctrl_d.load_small = 1'b1;
         end
         ST_ALIGN: begin
            ctrl_d.shift_right = w_align_amt;
            ctrl_d.mux01       = exp_diff_d[EXP_W-1];
            ctrl_d.mux02       = ~exp_diff_d[EXP_W-1];
         end
         ST_ADD: begin
            ctrl_d.mux_a      = 1'b1;
            ctrl_d.mux_sel    = 1'b1;
            ctrl_d.load_a     = 1'b1;
            ctrl_d.load_b     = 1'b1;
            ctrl_d.sum_or_mul = (op_d == OP_ADD);
            ctrl_d.big_op     = (op_d == OP_MUL) ? ALU_MUL : ALU_ADD;
         end
         ST_NORM: begin
            ctrl_d.shift_lr    = {{17{normalizeAmount[5]}}, normalizeAmount};
            ctrl_d.inc_dec_amt = w_norm_amt;
            ctrl_d.inc_dec_en  = (normalizeAmount != '0);
            ctrl_d.mux04       = 1'b1;
         end
         ST_ROUND: ctrl_d.mux05 = 1'b1;
         ST_DONE: begin
            ctrl_d.mux06 = 1'b1;
            ctrl_d.done  = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         op_q       <= OP_ADD;
         exp_diff_q <= '0;
         renorm_q   <= 1'b0;
         ctrl_q     <= '0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         exp_diff_q <= exp_diff_d;
         renorm_q   <= renorm_d;
         ctrl_q     <= ctrl_d;
      end
   end

   assign controlToMux01              = ctrl_q.mux01;
   assign controlToMux02              = ctrl_q.mux02;
   assign controlToMux03              = ctrl_q.mux03;
   assign controlToMux04              = ctrl_q.mux04;
   assign controlToMux05              = ctrl_q.mux05;
   assign controlToMux06              = ctrl_q.mux06;
   assign controlShiftRight           = ctrl_q.shift_right;
   assign controlToIncreaseOrDecrease = ctrl_q.inc_dec_amt;
   assign IncreaseOrDecreaseEnable    = ctrl_q.inc_dec_en;
   assign controlShiftLeftOrRight     = ctrl_q.shift_lr;
   assign muxAControl                 = ctrl_q.mux_a;
   assign muxBControl                 = ctrl_q.mux_b;
   assign muxControl                  = ctrl_q.mux_sel;
   assign sumOrMultiplication         = ctrl_q.sum_or_mul;
   assign loadRegA                    = ctrl_q.load_a;
   assign loadRegB                    = ctrl_q.load_b;
   assign bigALUOperation             = ctrl_q.big_op;
   assign muxAControlSmall            = ctrl_q.mux_a_small;
   assign muxBControlSmall            = ctrl_q.mux_b_small;
   assign loadRegSmall                = ctrl_q.load_small;
   assign smallALUOperation           = ctrl_q.small_op;
   assign busy                        = ctrl_q.busy;
   assign done                        = ctrl_q.done;

endmodule
`default_nettype wire

// File: tb/tb_floating_point_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_floating_point_control
// Purpose  : Scoreboard bench; expected per-cycle control vectors are queued
//            when an operation is launched and compared as the DUT steps.
// Revision : 1.0
// ============================================================================
module tb_floating_point_control;

   typedef struct packed {
      logic [2:0]  pad;
      logic        m1, m2, m3, m4, m5, m6;
      logic [7:0]  shr;
      logic [3:0]  incdec;
      logic        incen;
      logic [22:0] slr;
      logic        muxa, muxb, muxc, som, lda, ldb;
      logic [3:0]  bigop;
      logic        muxas, muxbs, lds;
      logic [3:0]  smallop;
      logic        busy, done;
   } vec_t;

   logic              clk;
   logic              reset_n;
   logic              start;
   logic              operation;
   logic signed [7:0] expDiff;
   logic signed [5:0] normalizeAmount;
   logic              roundCarry;
   logic              controlToMux01, controlToMux02, controlToMux03;
   logic              controlToMux04, controlToMux05, controlToMux06;
   logic [7:0]        controlShiftRight;
   logic [3:0]        controlToIncreaseOrDecrease;
   logic              IncreaseOrDecreaseEnable;
   logic signed [22:0] controlShiftLeftOrRight;
   logic              muxAControl, muxBControl, muxControl;
   logic              sumOrMultiplication, loadRegA, loadRegB;
   logic [3:0]        bigALUOperation;
   logic              muxAControlSmall, muxBControlSmall, loadRegSmall;
   logic [3:0]        smallALUOperation;
   logic              busy, done;

   vec_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   op_idx   = 0;

   floating_point_control #(
      .EXP_W  (8),
      .MANT_W (23)
   ) dut (
      .clk                         (clk),
      .reset_n                     (reset_n),
      .start                       (start),
      .operation                   (operation),
      .expDiff                     (expDiff),
      .normalizeAmount             (normalizeAmount),
      .roundCarry                  (roundCarry),
      .controlToMux01              (controlToMux01),
      .controlToMux02              (controlToMux02),
      .controlToMux03              (controlToMux03),
      .controlToMux04              (controlToMux04),
      .controlToMux05              (controlToMux05),
      .controlToMux06              (controlToMux06),
      .controlShiftRight           (controlShiftRight),
      .controlToIncreaseOrDecrease (controlToIncreaseOrDecrease),
      .IncreaseOrDecreaseEnable    (IncreaseOrDecreaseEnable),
      .controlShiftLeftOrRight     (controlShiftLeftOrRight),
      .muxAControl                 (muxAControl),
      .muxBControl                 (muxBControl),
      .muxControl                  (muxControl),
      .sumOrMultiplication         (sumOrMultiplication),
      .loadRegA                    (loadRegA),
      .loadRegB                    (loadRegB),
      .bigALUOperation             (bigALUOperation),
      .muxAControlSmall            (muxAControlSmall),
      .muxBControlSmall            (muxBControlSmall),
      .loadRegSmall                (loadRegSmall),
      .smallALUOperation           (smallALUOperation),
      .busy                        (busy),
      .done                        (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%h expected=%h", tag, act, exp);
      end
   endtask

   function automatic vec_t dut_vec();
      vec_t v;
      v         = '0;
      v.m1      = controlToMux01;
      v.m2      = controlToMux02;
      v.m3      = controlToMux03;
      v.m4      = controlToMux04;
      v.m5      = controlToMux05;
      v.m6      = controlToMux06;
      v.shr     = controlShiftRight;
      v.incdec  = controlToIncreaseOrDecrease;
      v.incen   = IncreaseOrDecreaseEnable;
      v.slr     = controlShiftLeftOrRight;
      v.muxa    = muxAControl;
      v.muxb    = muxBControl;
      v.muxc    = muxControl;
      v.som     = sumOrMultiplication;
      v.lda     = loadRegA;
      v.ldb     = loadRegB;
      v.bigop   = bigALUOperation;
      v.muxas   = muxAControlSmall;
      v.muxbs   = muxBControlSmall;
      v.lds     = loadRegSmall;
      v.smallop = smallALUOperation;
      v.busy    = busy;
      v.done    = done;
      return v;
   endfunction

   // Expected control vector for every cycle of one operation, then idle.
   task automatic push_op(input logic op, input int ed, input int namt, input logic rc,
                          output int lat);
      vec_t v;
      int   a;
      v = '0; v.busy = 1'b1; v.lds = 1'b1;
      v.smallop = op ? 4'b0000 : 4'b0011;
      sb_q.push_back(v);
      if (!op) begin
         a = (ed < 0) ? -ed : ed;
         if (a > 24) a = 24;
         v = '0; v.busy = 1'b1;
         v.shr = 8'(a);
         v.m1  = (ed < 0);
         v.m2  = !(ed < 0);
         sb_q.push_back(v);
      end
      v = '0; v.busy = 1'b1;
      v.muxa = 1'b1; v.muxc = 1'b1; v.lda = 1'b1; v.ldb = 1'b1;
      v.som   = !op;
      v.bigop = op ? 4'b0010 : 4'b0000;
      sb_q.push_back(v);
      for (int p = 0; p < (rc ? 2 : 1); p++) begin
         a = (namt < 0) ? -namt : namt;
         if (a > 15) a = 15;
         v = '0; v.busy = 1'b1;
         v.slr    = 23'(namt);
         v.incdec = 4'(a);
         v.incen  = (namt != 0);
         v.m4     = 1'b1;
         sb_q.push_back(v);
         v = '0; v.busy = 1'b1; v.m5 = 1'b1;
         sb_q.push_back(v);
      end
      v = '0; v.busy = 1'b1; v.m6 = 1'b1; v.done = 1'b1;
      sb_q.push_back(v);
      sb_q.push_back('0);
      lat = (op ? 5 : 6) + (rc ? 2 : 0);
   endtask

   task automatic run_op(input logic op, input int ed, input int namt, input logic rc,
                         input logic noise, input int abort_at);
      int   lat;
      int   cyc;
      int   done_cyc;
      vec_t exp_v;
      vec_t act_v;
      operation       = op;
      expDiff         = 8'(ed);
      normalizeAmount = 6'(namt);
      roundCarry      = rc;
      start           = 1'b1;
      push_op(op, ed, namt, rc, lat);
      op_idx++;
      cyc      = 0;
      done_cyc = 0;
      while (sb_q.size() != 0) begin
         @(posedge clk);
         #1;
         cyc++;
         exp_v = sb_q.pop_front();
         act_v = dut_vec();
         check_val($sformatf("op%0d_cyc%0d", op_idx, cyc), act_v, exp_v);
         if (act_v.done && done_cyc == 0) done_cyc = cyc;
         start = (sb_q.size() != 0) ? noise : 1'b0;
         if (cyc == abort_at) begin
            #1 reset_n = 1'b0;
            #1 check_val($sformatf("op%0d_async_reset", op_idx), dut_vec(), '0);
            sb_q.delete();
            start = 1'b0;
            #1 reset_n = 1'b1;
            return;
         end
      end
      check_val($sformatf("op%0d_latency", op_idx), 64'(done_cyc), 64'(lat));
   endtask

   initial begin
      reset_n         = 1'b0;
      start           = 1'b0;
      operation       = 1'b0;
      expDiff         = '0;
      normalizeAmount = '0;
      roundCarry      = 1'b0;

      for (int i = 0; i < 4; i++) begin
         start           = 1'($urandom);
         operation       = 1'($urandom);
         expDiff         = 8'($urandom);
         normalizeAmount = 6'($urandom);
         roundCarry      = 1'($urandom);
         @(posedge clk);
         #1;
         check_val($sformatf("reset_%0d", i), dut_vec(), '0);
      end
      start           = 1'b0;
      operation       = 1'b0;
      expDiff         = '0;
      normalizeAmount = '0;
      roundCarry      = 1'b0;
      #2 reset_n = 1'b1;

      // Directed: 0.75+2.25, alignment boundaries, renormalize, multiply with stray starts.
      run_op(1'b0,   -2,   0, 1'b0, 1'b0, 0);
      run_op(1'b0,   40,   1, 1'b0, 1'b0, 0);
      run_op(1'b0, -128,  -1, 1'b0, 1'b0, 0);
      run_op(1'b0,   24,   3, 1'b0, 1'b0, 0);
      run_op(1'b0,    5, -20, 1'b1, 1'b0, 0);
      run_op(1'b1,    3,   1, 1'b0, 1'b1, 0);
      run_op(1'b1,   -7,   0, 1'b1, 1'b1, 0);
      // Reset lands during ADD; the following add must run its full course.
      run_op(1'b0,    1,   2, 1'b1, 1'b0, 3);
      run_op(1'b0,   -2,   0, 1'b0, 1'b0, 0);

      for (int k = 0; k < 8; k++) begin
         run_op(1'($urandom), int'($urandom_range(0, 255)) - 128,
                int'($urandom_range(0, 63)) - 32, 1'($urandom), 1'($urandom), 0);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/floating_point_control.md
FLOATING_POINT_CONTROL -- requirements
Module: floating_point_control

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent width.
REQ-002 SHALL have parameter MANT_W, default 23, mantissa field width; alignment saturates at MANT_W+1.
REQ-003 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, request one operation; sampled in IDLE only.
REQ-006 SHALL have port operation, input, 1, 0 = add, 1 = multiply; captured with start.
REQ-007 SHALL have port expDiff, input, signed EXP_W, small-ALU result exp1-exp2.
REQ-008 SHALL have port normalizeAmount, input, signed 6, datapath normalize shift (+ right, - left).
REQ-009 SHALL have port roundCarry, input, 1, rounding overflowed the mantissa.
REQ-010 SHALL have port controlToMux01..controlToMux06, output, 1 each, datapath mux selects.
REQ-011 SHALL have port controlShiftRight, output, 8, alignment shift amount.
REQ-012 SHALL have port controlToIncreaseOrDecrease, output, 4, exponent adjust amount.
REQ-013 SHALL have port IncreaseOrDecreaseEnable, output, 1, exponent adjust enable.
REQ-014 SHALL have port controlShiftLeftOrRight, output, signed 23, normalize shift.
REQ-015 SHALL have ports muxAControl, muxBControl, muxControl, sumOrMultiplication, loadRegA, loadRegB, output, 1 each, big-ALU controls.
REQ-016 SHALL have port bigALUOperation, output, 4, big-ALU opcode.
REQ-017 SHALL have ports muxAControlSmall, muxBControlSmall, loadRegSmall, output, 1 each, small-ALU controls.
REQ-018 SHALL have port smallALUOperation, output, 4, small-ALU opcode.
REQ-019 SHALL have ports busy and done, output, 1 each, status; done is a one-cycle pulse.

Function
REQ-020 SHALL be a Moore FSM; all outputs SHALL be registered and SHALL depend only on state and captured values.
REQ-021 SHALL use states IDLE, EXP, ALIGN, ADD, NORM, ROUND, DONE.
REQ-022 IDLE with start=1 SHALL go to EXP next cycle; busy SHALL be 1 in every state except IDLE.
REQ-023 In EXP, smallALUOperation SHALL be 0011 (subtract) for add and 0000 (add) for multiply; muxA/BControlSmall=0; loadRegSmall=1.
REQ-024 EXP SHALL go to ALIGN for add and to ADD for multiply; expDiff SHALL be captured on leaving EXP.
REQ-025 In ALIGN, controlShiftRight SHALL be min(|expDiff|, MANT_W+1), expDiff=-128 included; controlToMux01=1 and controlToMux02=0 when expDiff<0, else the inverse.
REQ-026 In ADD: muxAControl=1, muxBControl=0, muxControl=1, loadRegA=1, loadRegB=1; sumOrMultiplication=1 and bigALUOperation=0000 for add; sumOrMultiplication=0 and bigALUOperation=0010 for multiply.
REQ-027 In NORM: controlShiftLeftOrRight = sign-extended normalizeAmount; controlToIncreaseOrDecrease = min(|normalizeAmount|,15); IncreaseOrDecreaseEnable = (normalizeAmount!=0); controlToMux04=1.
REQ-028 In ROUND, controlToMux05=1; roundCarry=1 SHALL return to NORM once only, with the second ROUND going to DONE regardless.
REQ-029 In DONE, controlToMux06=1 and done=1 for one cycle; DONE SHALL go to IDLE.
REQ-030 Latency start-to-done: add 6 cycles; multiply 5; plus 2 with renormalize.
REQ-031 start while busy SHALL be ignored; start in the DONE cycle SHALL be ignored.
REQ-032 Any control output not named for the current state SHALL be 0.

Reset
REQ-033 reset_n=0 SHALL immediately force IDLE, all outputs 0, and clear the captured operation, expDiff, and renormalize flag, including mid-operation.
REQ-034 The first start SHALL be accepted on the first rising edge with reset_n=1.

Structure
REQ-035 Package fp_ctrl_pkg SHALL hold the state enum, ALU opcodes (ALU_ADD=0000, ALU_MUL=0010, ALU_SUB=0011), and MAX_ALIGN.
REQ-036 Saturating absolute value SHALL be one sub-module, fp_ctrl_sat_abs, used for ALIGN and NORM.

Verification
REQ-037 Assert reset_n=0 with random inputs -> all outputs 0, busy=0.
REQ-038 Add, expDiff=-2 (0.75+2.25) -> ALIGN: shift=2, Mux01=1, Mux02=0; ADD: bigALUOperation=0000; done at cycle 6.
REQ-039 Add, expDiff=+40 -> controlShiftRight=24, Mux01=0; expDiff=-128 -> 24.
REQ-040 normalizeAmount=-20, roundCarry=1 on first ROUND -> increase/decrease amount=15, NORM repeated, done at cycle 8.
REQ-041 Multiply -> ALIGN skipped, sumOrMultiplication=0, done at cycle 5; start pulses while busy ignored.
REQ-042 reset_n pulsed low during ADD -> IDLE at once, outputs 0; start next cycle -> normal 6-cycle add.
